// File: rtl/timer_capture_compare_chn.sv
// One capture/compare channel fed by the basic timer: PWM from a period-shadowed compare
// value, or capture of the timer count on a filtered pin edge. Macro TIMER_CAP_FILTER_EN builds the glitch filter.
module timer_capture_compare_chn #(
    parameter int timer_width      = 16,
    parameter int filter_width     = 8,
    parameter int simulation_delay = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [timer_width-1:0]  timer_cnt_now_v,
    input  logic                    timer_expired,
    input  logic                    timer_started,
    input  logic                    cc_mode,
    input  logic [timer_width-1:0]  cmp_v,
    input  logic [1:0]              cap_edge,
    input  logic [filter_width-1:0] cap_filter_th,
    input  logic                    cap_in,
    output logic                    pwm_o,
    output logic [timer_width-1:0]  cap_v,
    output logic                    cap_vld,
    output logic                    cap_itr_req
);

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;

    // Register update delay applies to behavioural models only; this RTL updates at the edge.
    localparam int unused_sim_delay = simulation_delay;

    logic [timer_width-1:0] cmp_shadow_q, cmp_shadow_d;
    logic                   pwm_q, pwm_d;
    logic [1:0]             sync_q;
    logic                   filt_q, filt_d;
    logic [timer_width-1:0] cap_v_q, cap_v_d;
    logic                   cap_vld_q, cap_vld_d;
    logic                   cap_itr_q;
    logic                   edge_match_s;

    // Compare shadow reloads only between periods; PWM uses the shadow of the current period.
    always_comb begin
        cmp_shadow_d = cmp_shadow_q;
        if (!timer_started || timer_expired) begin
            cmp_shadow_d = cmp_v;
        end else begin
            cmp_shadow_d = cmp_shadow_q;
        end
        pwm_d = !cc_mode && timer_started && (timer_cnt_now_v < cmp_shadow_q);
    end

`ifdef TIMER_CAP_FILTER_EN
    localparam logic [filter_width-1:0] FC_ONE = {{(filter_width-1){1'b0}}, 1'b1};

    logic [filter_width-1:0] fc_q, fc_d;

    // Accept a new level only after it differs from filt for cap_filter_th+1 cycles.
    always_comb begin
        fc_d   = fc_q;
        filt_d = filt_q;
        if (sync_q[1] == filt_q) begin
            fc_d = {filter_width{1'b0}};
        end else if (fc_q == cap_filter_th) begin
            fc_d   = {filter_width{1'b0}};
            filt_d = sync_q[1];
        end else begin
            fc_d = fc_q + FC_ONE;
        end
    end

    // Filter counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= {filter_width{1'b0}};
        end else begin
            fc_q <= fc_d;
        end
    end
`else
    logic unused_filter_th;
    assign unused_filter_th = ^cap_filter_th;

    // Without the filter the synchronised level is accepted every cycle.
    always_comb begin
        filt_d = sync_q[1];
    end
`endif

    // Qualify the accepted level change against the selected edge and latch the count.
    always_comb begin
        edge_match_s = 1'b0;
        case (cap_edge)
            EDGE_RISE: edge_match_s = filt_d & ~filt_q;
            EDGE_FALL: edge_match_s = ~filt_d & filt_q;
            EDGE_BOTH: edge_match_s = filt_d ^ filt_q;
            default:   edge_match_s = 1'b0;
        endcase
        cap_vld_d = edge_match_s & cc_mode & timer_started;
        if (cap_vld_d) begin
            cap_v_d = timer_cnt_now_v;
        end else begin
            cap_v_d = cap_v_q;
        end
    end

    // Channel state registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_shadow_q <= {timer_width{1'b0}};
            pwm_q        <= 1'b0;
            sync_q       <= 2'b00;
            filt_q       <= 1'b0;
            cap_v_q      <= {timer_width{1'b0}};
            cap_vld_q    <= 1'b0;
            cap_itr_q    <= 1'b0;
        end else begin
            cmp_shadow_q <= cmp_shadow_d;
            pwm_q        <= pwm_d;
            sync_q       <= {sync_q[0], cap_in};
            filt_q       <= filt_d;
            cap_v_q      <= cap_v_d;
            cap_vld_q    <= cap_vld_d;
            cap_itr_q    <= cap_vld_q;
        end
    end

    assign pwm_o       = pwm_q;
    assign cap_v       = cap_v_q;
    assign cap_vld     = cap_vld_q;
    assign cap_itr_req = cap_itr_q;

endmodule
